// File: rtl/edge_highlighter.sv
// Level-to-pulse edge detector with independent retriggerable stretchers on
// the rising and falling outputs; input synchronizer enabled by EDGE_HIGHLIGHTER_SYNC_EN.
module edge_highlighter #(
  parameter int SYNC_STAGES  = 2,
  parameter int PULSE_CYCLES = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic signal_in,
  output logic rising_edge,
  output logic falling_edge
);

  localparam int CW = $clog2(PULSE_CYCLES + 1);
  localparam logic [CW-1:0] LOAD = CW'(PULSE_CYCLES);

  generate
    if (SYNC_STAGES < 2 || SYNC_STAGES > 4) begin : g_bad_sync
      $error("edge_highlighter: SYNC_STAGES must be 2..4");
    end
    if (PULSE_CYCLES < 1 || PULSE_CYCLES > 255) begin : g_bad_pulse
      $error("edge_highlighter: PULSE_CYCLES must be 1..255");
    end
  endgenerate

  logic s;
  logic h;

`ifdef EDGE_HIGHLIGHTER_SYNC_EN
  logic [SYNC_STAGES-1:0] sync_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) sync_q <= '0;
    else     sync_q <= {sync_q[SYNC_STAGES-2:0], signal_in};
  end

  assign s = sync_q[SYNC_STAGES-1];
`else
  assign s = signal_in;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) h <= 1'b0;
    else     h <= s;
  end

  logic rise_evt;
  logic fall_evt;
  assign rise_evt = s & ~h;
  assign fall_evt = ~s & h;

  logic [CW-1:0] rise_cnt;
  logic [CW-1:0] fall_cnt;
  logic [CW-1:0] rise_dec;
  logic [CW-1:0] fall_dec;

  // Saturating decrement; output is the registered "next count is nonzero".
  always_comb begin
    rise_dec = '0;
    fall_dec = '0;
    if (rise_cnt != '0) rise_dec = rise_cnt - CW'(1);
    if (fall_cnt != '0) fall_dec = fall_cnt - CW'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rise_cnt    <= '0;
      rising_edge <= 1'b0;
    end else if (rise_evt) begin
      rise_cnt    <= LOAD;
      rising_edge <= 1'b1;
    end else begin
      rise_cnt    <= rise_dec;
      rising_edge <= (rise_dec != '0);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fall_cnt     <= '0;
      falling_edge <= 1'b0;
    end else if (fall_evt) begin
      fall_cnt     <= LOAD;
      falling_edge <= 1'b1;
    end else begin
      fall_cnt     <= fall_dec;
      falling_edge <= (fall_dec != '0);
    end
  end

endmodule

// File: tb/tb_edge_highlighter.sv
// Bench for edge_highlighter: a default instance and a PULSE_CYCLES=3 instance
// checked every cycle against an event-history model of the edge/pulse rules.
module tb_edge_highlighter;

`ifdef EDGE_HIGHLIGHTER_SYNC_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic signal_in = 1'b0;
  logic r1, f1, r2, f2;

  int compared = 0;
  int mismatched = 0;

  bit samp [0:4095];
  int n = 0;
  logic [3:0] obs_vec;
  logic [3:0] exp_vec;

  always #5 clk = ~clk;

  edge_highlighter u_dut1 (
    .clk(clk), .rst(rst), .signal_in(signal_in),
    .rising_edge(r1), .falling_edge(f1)
  );

  edge_highlighter #(.SYNC_STAGES(2), .PULSE_CYCLES(3)) u_dut3 (
    .clk(clk), .rst(rst), .signal_in(signal_in),
    .rising_edge(r2), .falling_edge(f2)
  );

  // Value of the sampled input s at edge k (edges counted from reset release).
  function automatic bit s_at(int k);
    if (k - LAT < 0) return 1'b0;
    return samp[k - LAT];
  endfunction

  function automatic bit evt_at(int k, bit rise);
    bit s, h;
    s = s_at(k);
    h = (k > 0) ? s_at(k - 1) : 1'b0;
    return rise ? (s & ~h) : (~s & h);
  endfunction

  // Output is high after edge k iff a matching event occurred in the last p edges.
  function automatic bit exp_out(int k, int p, bit rise);
    for (int j = k; j >= 0 && j > k - p; j--)
      if (evt_at(j, rise)) return 1'b1;
    return 1'b0;
  endfunction

  task automatic step(input bit v);
    signal_in = v;
    @(posedge clk);
    samp[n] = v;
    #1;
    obs_vec = {r1, f1, r2, f2};
    exp_vec = {exp_out(n, 1, 1'b1), exp_out(n, 1, 1'b0),
               exp_out(n, 3, 1'b1), exp_out(n, 3, 1'b0)};
    n++;
  endtask

  task automatic test_reset;
    #2;
    compared++;
    if ({r1, f1, r2, f2} !== 4'b0000) begin
      mismatched++;
      $display("FAIL reset_state: got %b need 0000", {r1, f1, r2, f2});
    end
    @(negedge clk);
    rst = 1'b0;
    n = 0;
  endtask

  task automatic test_idle;
    for (int i = 0; i < 9; i++) begin
      step(1'b0);
      compared++;
      if (obs_vec !== exp_vec) begin
        mismatched++;
        $display("FAIL idle cyc %0d: got %b need %b", n, obs_vec, exp_vec);
      end
    end
  endtask

  task automatic test_rise_fall;
    logic [11:0] pat;
    pat = 12'b000111111000;
    for (int i = 11; i >= 0; i--) begin
      step(pat[i]);
      compared++;
      if (obs_vec !== exp_vec) begin
        mismatched++;
        $display("FAIL rise_fall cyc %0d: got %b need %b", n, obs_vec, exp_vec);
      end
    end
  endtask

  task automatic test_short_high;
    logic [7:0] pat;
    pat = 8'b01000000;
    for (int i = 7; i >= 0; i--) begin
      step(pat[i]);
      compared++;
      if (obs_vec !== exp_vec) begin
        mismatched++;
        $display("FAIL short_high cyc %0d: got %b need %b", n, obs_vec, exp_vec);
      end
    end
  endtask

  task automatic test_back_to_back;
    logic [15:0] pat;
    pat = 16'b1010101001100000;
    for (int i = 15; i >= 0; i--) begin
      step(pat[i]);
      compared++;
      if (obs_vec !== exp_vec) begin
        mismatched++;
        $display("FAIL back_to_back cyc %0d: got %b need %b", n, obs_vec, exp_vec);
      end
    end
  endtask

  task automatic test_retrigger;
    logic [15:0] pat;
    pat = 16'b1101101100000000;
    for (int i = 15; i >= 0; i--) begin
      step(pat[i]);
      compared++;
      if (obs_vec !== exp_vec) begin
        mismatched++;
        $display("FAIL retrigger cyc %0d: got %b need %b", n, obs_vec, exp_vec);
      end
    end
  endtask

  task automatic test_reset_mid_pulse;
    for (int i = 0; i < 6; i++) step(1'b0);
    step(1'b1);
    step(1'b1);
    step(1'b1);
    compared++;
    if (obs_vec !== exp_vec) begin
      mismatched++;
      $display("FAIL pre_reset_pulse: got %b need %b", obs_vec, exp_vec);
    end
    step(1'b0);
    #2;
    rst = 1'b1;
    #1;
    compared++;
    if ({r1, f1, r2, f2} !== 4'b0000) begin
      mismatched++;
      $display("FAIL reset_mid_pulse: got %b need 0000", {r1, f1, r2, f2});
    end
    signal_in = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    compared++;
    if ({r1, f1, r2, f2} !== 4'b0000) begin
      mismatched++;
      $display("FAIL held_in_reset: got %b need 0000", {r1, f1, r2, f2});
    end
    @(negedge clk);
    rst = 1'b0;
    n = 0;
    for (int i = 0; i < 8; i++) begin
      step(1'b1);
      compared++;
      if (obs_vec !== exp_vec) begin
        mismatched++;
        $display("FAIL release_high cyc %0d: got %b need %b", n, obs_vec, exp_vec);
      end
    end
  endtask

  task automatic test_random;
    bit v;
    int run;
    v = 1'b0;
    run = 0;
    for (int i = 0; i < 400; i++) begin
      if (run == 0) begin
        v = ~v;
        run = $urandom_range(1, 5);
      end
      run--;
      step(v);
      compared++;
      if (obs_vec !== exp_vec) begin
        mismatched++;
        $display("FAIL random cyc %0d: got %b need %b", n, obs_vec, exp_vec);
      end
    end
  endtask

  initial begin
    test_reset();
    test_idle();
    test_rise_fall();
    test_short_high();
    test_back_to_back();
    test_retrigger();
    test_reset_mid_pulse();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
